// File: rtl/framebuffer_arbiter_if.sv
// CPU request/response, clear-engine control and framebuffer port-A signals
// shared between the arbiter and its surroundings.
interface framebuffer_arbiter_if #(
    parameter int ADDRESS_WIDTH = 12
);
    logic                     cpu_valid;
    logic                     cpu_ready;
    logic                     cpu_wr;
    logic [1:0]               cpu_mask;
    logic [ADDRESS_WIDTH-1:0] cpu_addr;
    logic [15:0]              cpu_wdata;
    logic [15:0]              cpu_rdata;
    logic                     cpu_rvalid;

    logic                     clr_start;
    logic [15:0]              clr_fill;
    logic                     clr_busy;
    logic                     clr_done;

    logic                     fb_wr;
    logic [1:0]               fb_mask;
    logic [ADDRESS_WIDTH-1:0] fb_addr;
    logic [15:0]              fb_data;
    logic [15:0]              fb_q;

    modport slave (
        input  cpu_valid, cpu_wr, cpu_mask, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_rvalid,
        input  clr_start, clr_fill,
        output clr_busy, clr_done,
        output fb_wr, fb_mask, fb_addr, fb_data,
        input  fb_q
    );

    modport master (
        output cpu_valid, cpu_wr, cpu_mask, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_rvalid,
        output clr_start, clr_fill,
        input  clr_busy, clr_done,
        input  fb_wr, fb_mask, fb_addr, fb_data,
        output fb_q
    );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer arbiter: CPU read/write plus an optional clear engine
// (macro FRAMEBUFFER_CLEAR_EN) sharing port A one slot per cycle, round-robin.
module framebuffer_arbiter #(
    parameter int DEPTH         = 4096,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input logic                 clk,
    input logic                 rst_n,
    framebuffer_arbiter_if.slave bus
);

    logic                     grant_cpu;
    logic                     grant_clr;
    logic [ADDRESS_WIDTH-1:0] clr_addr;
    logic [15:0]              clr_word;
    logic [1:0]               vld_pipe;

`ifdef FRAMEBUFFER_CLEAR_EN
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    state_t state, state_nxt;
    logic   last_clr;
    logic   in_clear;

    assign in_clear = (state == CLEAR);

    // The clear engine always requests while in CLEAR, so the CPU only gets
    // the slot when the engine took the previous one.
    assign bus.cpu_ready = !in_clear || last_clr;
    assign grant_cpu     = bus.cpu_valid && bus.cpu_ready;
    assign grant_clr     = in_clear && !grant_cpu;
    assign bus.clr_busy  = (state != IDLE);
    assign bus.clr_done  = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.clr_start) state_nxt = CLEAR;
            CLEAR:   if (grant_clr && clr_addr == LAST_ADDR) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_addr <= '0;
            clr_word <= '0;
            last_clr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.clr_start) begin
                clr_addr <= '0;
                clr_word <= bus.clr_fill;
            end else if (grant_clr) begin
                clr_addr <= clr_addr + 1'b1;
            end
            if (grant_cpu)      last_clr <= 1'b0;
            else if (grant_clr) last_clr <= 1'b1;
        end
    end
`else
    logic unused_clr;

    assign unused_clr    = ^{bus.clr_start, bus.clr_fill};
    assign bus.cpu_ready = 1'b1;
    assign grant_cpu     = bus.cpu_valid;
    assign grant_clr     = 1'b0;
    assign clr_addr      = '0;
    assign clr_word      = '0;
    assign bus.clr_busy  = 1'b0;
    assign bus.clr_done  = 1'b0;
`endif

    // Idle slots drop fb_wr but keep the last address/mask/data on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fb_wr   <= 1'b0;
            bus.fb_mask <= '0;
            bus.fb_addr <= '0;
            bus.fb_data <= '0;
        end else if (grant_cpu) begin
            bus.fb_wr   <= bus.cpu_wr;
            bus.fb_mask <= bus.cpu_mask;
            bus.fb_addr <= bus.cpu_addr;
            bus.fb_data <= bus.cpu_wdata;
        end else if (grant_clr) begin
            bus.fb_wr   <= 1'b1;
            bus.fb_mask <= 2'b11;
            bus.fb_addr <= clr_addr;
            bus.fb_data <= clr_word;
        end else begin
            bus.fb_wr   <= 1'b0;
        end
    end

    // Stage 0: address on port A; stage 1: RAM data on fb_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[0], grant_cpu && !bus.cpu_wr};
    end

    assign bus.cpu_rvalid = vld_pipe[1];
    assign bus.cpu_rdata  = bus.fb_q;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Randomized bench for framebuffer_arbiter: a slot-level model with a shadow
// memory and a read-response queue is compared against the DUT every cycle.
module tb_framebuffer_arbiter;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef FRAMEBUFFER_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    framebuffer_arbiter_if #(.ADDRESS_WIDTH(AW)) bus ();
    framebuffer_arbiter #(.DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Framebuffer port A: synchronous RAM with byte enables.
    logic [15:0] ram [DEPTH];
    initial foreach (ram[i]) ram[i] = 16'h0;
    always @(posedge clk) begin
        if (bus.fb_wr) begin
            if (bus.fb_mask[0]) ram[bus.fb_addr][7:0]  <= bus.fb_data[7:0];
            if (bus.fb_mask[1]) ram[bus.fb_addr][15:8] <= bus.fb_data[15:8];
        end
        bus.fb_q <= ram[bus.fb_addr];
    end

    // Reference model.
    typedef struct { int due; logic [15:0] data; } rd_t;
    rd_t         rq[$];
    logic [15:0] shadow [DEPTH];
    bit          m_clearing, m_done, m_last_clr;
    int          m_cnt;
    logic [15:0] m_fill;
    logic        m_fb_wr;
    logic [1:0]  m_fb_mask;
    logic [AW-1:0] m_fb_addr;
    logic [15:0] m_fb_data;
    int          cyc = 0;

    initial foreach (shadow[i]) shadow[i] = 16'h0;

    always @(negedge clk) begin
        bit exp_ready, rv, g_cpu, g_clr, busy_old;
        if (!rst_n) begin
            chk("rst_fb_wr", bus.fb_wr, 0);
            chk("rst_fb_mask", bus.fb_mask, 0);
            chk("rst_fb_addr", bus.fb_addr, 0);
            chk("rst_fb_data", bus.fb_data, 0);
            chk("rst_rvalid", bus.cpu_rvalid, 0);
            chk("rst_clr_busy", bus.clr_busy, 0);
            chk("rst_clr_done", bus.clr_done, 0);
            m_clearing = 0; m_done = 0; m_last_clr = 0; m_cnt = 0; m_fill = 0;
            m_fb_wr = 0; m_fb_mask = 0; m_fb_addr = 0; m_fb_data = 0;
            rq.delete();
            foreach (shadow[i]) shadow[i] = ram[i];
        end else begin
            exp_ready = !CLR_EN || !m_clearing || m_last_clr;
            chk("cpu_ready", bus.cpu_ready, exp_ready);
            chk("clr_busy", bus.clr_busy, m_clearing || m_done);
            chk("clr_done", bus.clr_done, m_done);
            chk("fb_wr", bus.fb_wr, m_fb_wr);
            chk("fb_mask", bus.fb_mask, m_fb_mask);
            chk("fb_addr", bus.fb_addr, m_fb_addr);
            chk("fb_data", bus.fb_data, m_fb_data);
            rv = (rq.size() > 0) && (rq[0].due == cyc);
            chk("cpu_rvalid", bus.cpu_rvalid, rv);
            if (rv) begin
                chk("cpu_rdata", bus.cpu_rdata, rq[0].data);
                void'(rq.pop_front());
            end

            busy_old = m_clearing || m_done;
            m_done = 0;
            g_cpu = bus.cpu_valid && exp_ready;
            g_clr = m_clearing && !g_cpu;
            if (g_cpu) begin
                m_fb_wr = bus.cpu_wr; m_fb_mask = bus.cpu_mask;
                m_fb_addr = bus.cpu_addr; m_fb_data = bus.cpu_wdata;
                if (bus.cpu_wr) begin
                    if (bus.cpu_mask[0]) shadow[bus.cpu_addr][7:0]  = bus.cpu_wdata[7:0];
                    if (bus.cpu_mask[1]) shadow[bus.cpu_addr][15:8] = bus.cpu_wdata[15:8];
                end else begin
                    rq.push_back('{cyc + 2, shadow[bus.cpu_addr]});
                end
                m_last_clr = 0;
            end else if (g_clr) begin
                m_fb_wr = 1; m_fb_mask = 2'b11; m_fb_addr = AW'(m_cnt); m_fb_data = m_fill;
                shadow[m_cnt] = m_fill;
                if (m_cnt == DEPTH - 1) begin
                    m_clearing = 0;
                    m_done = 1;
                end
                m_cnt++;
                m_last_clr = 1;
            end else begin
                m_fb_wr = 0;
            end
            if (CLR_EN && !busy_old && bus.clr_start) begin
                m_clearing = 1; m_cnt = 0; m_fill = bus.clr_fill;
            end
        end
        cyc++;
    end

    // Stimulus helpers: called and return at posedge+1.
    task automatic cpu_req(input bit wr, input logic [1:0] m, input logic [AW-1:0] a,
                           input logic [15:0] d, output logic [15:0] rd);
        bit acc = 0, got = 0;
        int n = 0;
        bus.cpu_valid = 1; bus.cpu_wr = wr; bus.cpu_mask = m; bus.cpu_addr = a; bus.cpu_wdata = d;
        while (!acc && n < 100) begin
            @(negedge clk); acc = bus.cpu_ready;
            @(posedge clk); #1; n++;
        end
        bus.cpu_valid = 0;
        if (!acc) chk("req_timeout", 0, 1);
        rd = 16'h0;
        if (!wr && acc) begin
            n = 0;
            while (!got && n < 6) begin
                @(negedge clk); n++;
                if (bus.cpu_rvalid) begin got = 1; rd = bus.cpu_rdata; end
            end
            chk("rd_latency", n, 2);
            @(posedge clk); #1;
        end
    endtask

    task automatic rand_traffic(input int n, input int clr_pct);
        repeat (n) begin
            bus.cpu_valid = 1'($urandom_range(0, 1));
            bus.cpu_wr    = 1'($urandom_range(0, 1));
            bus.cpu_mask  = 2'($urandom_range(0, 3));
            bus.cpu_addr  = AW'($urandom_range(0, DEPTH - 1));
            bus.cpu_wdata = 16'($urandom);
            bus.clr_start = ($urandom_range(0, 99) < clr_pct);
            bus.clr_fill  = 16'($urandom);
            @(posedge clk); #1;
        end
        bus.cpu_valid = 0; bus.clr_start = 0;
    endtask

    initial begin
        logic [15:0] rd;
        int n, n_wr, k;
        bit ok, done_seen, prev_wr;
        bus.cpu_valid = 0; bus.cpu_wr = 0; bus.cpu_mask = 0; bus.cpu_addr = 0;
        bus.cpu_wdata = 0; bus.clr_start = 0; bus.clr_fill = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        cpu_req(1, 2'b11, 4'd5, 16'hBEEF, rd);
        cpu_req(0, 2'b00, 4'd5, 16'h0, rd);
        chk("read_beef", rd, 16'hBEEF);

        cpu_req(1, 2'b11, 4'd7, 16'h1234, rd);
        cpu_req(1, 2'b10, 4'd7, 16'hAB00, rd);
        cpu_req(0, 2'b00, 4'd7, 16'h0, rd);
        chk("byte_mask", rd, 16'hAB34);

        rand_traffic(200, 0);
        repeat (3) @(posedge clk); #1;

`ifdef FRAMEBUFFER_CLEAR_EN
        // Clear with the CPU idle.
        bus.clr_fill = 16'h5A5A; bus.clr_start = 1;
        @(posedge clk); #1; bus.clr_start = 0;
        n_wr = 0; ok = 1; done_seen = 0; k = 0;
        while (!done_seen && k < 100) begin
            @(negedge clk); k++;
            if (bus.fb_wr) begin
                if (bus.fb_addr != AW'(n_wr)) ok = 0;
                n_wr++;
            end
            if (bus.clr_done) done_seen = 1;
        end
        chk("clr_wr_count", n_wr, 16);
        chk("clr_addr_seq", ok, 1);
        chk("clr_done_cycle", k, 17);
        @(posedge clk); #1;
        for (int a = 0; a < DEPTH; a++) begin
            cpu_req(0, 2'b00, AW'(a), 16'h0, rd);
            chk("clr_fill_rd", rd, 16'h5A5A);
        end

        // Continuous reads during a clear: clear and CPU slots alternate.
        bus.cpu_valid = 1; bus.cpu_wr = 0; bus.clr_fill = 16'hC3C3; bus.clr_start = 1;
        @(posedge clk); #1; bus.clr_start = 0;
        n_wr = 0; ok = 1; done_seen = 0; k = 0; prev_wr = 0;
        while (!done_seen && k < 100) begin
            bus.cpu_addr = AW'($urandom_range(0, DEPTH - 1));
            @(negedge clk); k++;
            if (k >= 3 && bus.fb_wr == prev_wr) ok = 0;
            prev_wr = bus.fb_wr;
            if (bus.fb_wr) n_wr++;
            if (bus.clr_done) done_seen = 1;
            @(posedge clk); #1;
        end
        bus.cpu_valid = 0;
        chk("cont_clr_writes", n_wr, 16);
        chk("cont_alternate", ok, 1);
        chk("cont_done_seen", done_seen, 1);
        repeat (4) @(posedge clk); #1;

        // Re-start ignored mid-clear, then reset at address 8.
        bus.clr_fill = 16'h7777; bus.clr_start = 1;
        @(posedge clk); #1; bus.clr_start = 0;
        k = 0;
        while (!(bus.fb_wr && bus.fb_addr == 4'd4) && k < 50) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        bus.clr_fill = 16'h1111; bus.clr_start = 1;
        @(posedge clk); #1; bus.clr_start = 0;
        k = 0;
        while (!(bus.fb_wr && bus.fb_addr == 4'd8) && k < 50) begin @(negedge clk); k++; end
        chk("restart_ignored_data", bus.fb_data, 16'h7777);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("async_busy_clear", bus.clr_busy, 0);
        chk("async_fb_wr_clear", bus.fb_wr, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1;
        n = 0;
        repeat (30) begin @(negedge clk); if (bus.clr_done) n++; end
        chk("no_done_after_rst", n, 0);
        @(posedge clk); #1;

        rand_traffic(600, 3);
`else
        bus.clr_fill = 16'h5A5A; bus.clr_start = 1;
        @(posedge clk); #1; bus.clr_start = 0;
        n = 0;
        repeat (20) begin @(negedge clk); if (bus.clr_busy) n++; end
        chk("noclr_busy", n, 0);
        @(posedge clk); #1;
        bus.cpu_valid = 1; bus.cpu_wr = 0;
        n = 0;
        repeat (20) begin
            bus.cpu_addr = AW'($urandom_range(0, DEPTH - 1));
            @(negedge clk); if (bus.cpu_ready) n++;
            @(posedge clk); #1;
        end
        bus.cpu_valid = 0;
        chk("noclr_throughput", n, 20);
        rand_traffic(300, 5);
`endif

        repeat (5) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
